uart_instr_loader: RTL and testbench

Serial loader that receives test-instruction words over UART_RXD and writes them into the harness instruction memory (blk_mem_gen_0 port A write side). It lets the on-FPGA ESFA self-test harness run a host-supplied program instead of a fixed ROM image. It reports how many instructions were loaded, so the harness can use that value as its highest-instruction bound. The block is the write-side counterpart of the harness's sequential instruction reader.

---
 rtl/uart_instr_loader.sv | 217 +++++++++++++++++++++
 tb/tb_uart_instr_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_instr_loader.sv
// UART instruction loader: receives a count byte N followed by N words of WORD_BYTES
// bytes (LSB first) and writes each completed word into the instruction memory port A.
`timescale 1ns / 1ps

module uart_instr_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned WORD_BYTES   = 7,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    UART_RXD,
  output logic                    wea,
  output logic [ADDR_W-1:0]       addra,
  output logic [8*WORD_BYTES-1:0] dina,
  output logic [ADDR_W-1:0]       instr_count,
  output logic                    load_done,
  output logic                    frame_err
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PosW   = $clog2(WORD_BYTES);
  localparam int unsigned DataW  = 8 * WORD_BYTES;
  localparam int unsigned AsmW   = 8 * (WORD_BYTES - 1);

  localparam logic [TimerW-1:0] HalfBit = TimerW'(CLKS_PER_BIT / 2);
  localparam logic [TimerW-1:0] BitEnd  = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [PosW-1:0]   LastPos = PosW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {LHdr, LData, LDone} ld_state_e;

  // Synchroniser and edge-detect history
  logic rx_meta_q, rx_meta_d;
  logic rxs_q, rxs_d;
  logic rxs_prev_q, rxs_prev_d;

  // Receiver
  rx_state_e         rx_state_q, rx_state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_stb;
  logic              stop_err;

  // Loader
  ld_state_e         ld_state_q, ld_state_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [PosW-1:0]   pos_q, pos_d;
  logic [AsmW-1:0]   asm_q, asm_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DataW-1:0]  dina_q, dina_d;
  logic [ADDR_W-1:0] instr_count_q, instr_count_d;
  logic              load_done_q, load_done_d;
  logic              frame_err_q, frame_err_d;

  always_comb begin
    rx_meta_d  = UART_RXD;
    rxs_d      = rx_meta_q;
    rxs_prev_d = rxs_q;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_stb   = 1'b0;
    stop_err   = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        // Only a fresh falling edge starts a frame; a line stuck low is ignored.
        if (rxs_prev_q && !rxs_q) begin
          rx_state_d = RxStart;
          timer_d    = '0;
        end
      end
      RxStart: begin
        if (timer_q == HalfBit) begin
          timer_d    = '0;
          bit_idx_d  = '0;
          rx_state_d = rxs_q ? RxIdle : RxData;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RxData: begin
        if (timer_q == BitEnd) begin
          timer_d = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RxStop: begin
        if (timer_q == BitEnd) begin
          timer_d    = '0;
          rx_state_d = RxIdle;
          if (rxs_q) begin
            byte_stb = 1'b1;
          end else begin
            stop_err = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    ld_state_d    = ld_state_q;
    word_idx_d    = word_idx_q;
    pos_d         = pos_q;
    asm_d         = asm_q;
    wea_d         = 1'b0;
    addra_d       = addra_q;
    dina_d        = dina_q;
    instr_count_d = instr_count_q;
    // Registering the state delays load_done one cycle past the final wea.
    load_done_d   = load_done_q | (ld_state_q == LDone);
    frame_err_d   = frame_err_q | stop_err;
    unique case (ld_state_q)
      LHdr: begin
        if (byte_stb) begin
          instr_count_d = ADDR_W'(shift_q);
          word_idx_d    = '0;
          pos_d         = '0;
          if (shift_q == 8'd0) begin
            ld_state_d  = LDone;
            load_done_d = 1'b1;
          end else begin
            ld_state_d = LData;
          end
        end
      end
      LData: begin
        if (byte_stb) begin
          if (pos_q == LastPos) begin
            dina_d     = {shift_q, asm_q};
            wea_d      = 1'b1;
            addra_d    = word_idx_q;
            word_idx_d = word_idx_q + 1'b1;
            pos_d      = '0;
            if (word_idx_d == instr_count_q) begin
              ld_state_d = LDone;
            end
          end else begin
            for (int unsigned b = 0; b < WORD_BYTES - 1; b++) begin
              if (pos_q == PosW'(b)) begin
                asm_d[8*b +: 8] = shift_q;
              end
            end
            pos_d = pos_q + 1'b1;
          end
        end
      end
      LDone: ;
      default: ld_state_d = LHdr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      rxs_prev_q    <= 1'b1;
      rx_state_q    <= RxIdle;
      timer_q       <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      ld_state_q    <= LHdr;
      word_idx_q    <= '0;
      pos_q         <= '0;
      asm_q         <= '0;
      wea_q         <= 1'b0;
      addra_q       <= '0;
      dina_q        <= '0;
      instr_count_q <= '0;
      load_done_q   <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rxs_q         <= rxs_d;
      rxs_prev_q    <= rxs_prev_d;
      rx_state_q    <= rx_state_d;
      timer_q       <= timer_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      ld_state_q    <= ld_state_d;
      word_idx_q    <= word_idx_d;
      pos_q         <= pos_d;
      asm_q         <= asm_d;
      wea_q         <= wea_d;
      addra_q       <= addra_d;
      dina_q        <= dina_d;
      instr_count_q <= instr_count_d;
      load_done_q   <= load_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign wea         = wea_q;
  assign addra       = addra_q;
  assign dina        = dina_q;
  assign instr_count = instr_count_q;
  assign load_done   = load_done_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader: serial stimulus, write scoreboard, immediate assertions.
`timescale 1ns / 1ps

module tb_uart_instr_loader;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Wb  = 7;
  localparam int unsigned Aw  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rxd = 1'b1;
  logic            wea;
  logic [Aw-1:0]   addra;
  logic [8*Wb-1:0] dina;
  logic [Aw-1:0]   instr_count;
  logic            load_done;
  logic            frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wea_cnt = 0;
  int last_wea_cyc = -1;
  int done_cyc = -1;
  logic        wea_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_wr;

  uart_instr_loader #(
    .CLKS_PER_BIT(Cpb),
    .WORD_BYTES  (Wb),
    .ADDR_W      (Aw)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .UART_RXD   (rxd),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .instr_count(instr_count),
    .load_done  (load_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every wea pops the oldest expected {addr, data}
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      wea_cnt++;
      last_wea_cyc = cyc;
      check("wea_single_cycle", 64'(wea_prev), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_wea: observed addr=%0h data=%0h expected no write", addra, dina);
      end else begin
        exp_wr = exp_q.pop_front();
        check("wr_addr", 64'(addra), 64'(exp_wr[63:56]));
        check("wr_data", 64'(dina), 64'(exp_wr[55:0]));
      end
    end
    if (load_done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
    wea_prev  = wea;
    done_prev = load_done;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
    rxd = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rxd = stop;
    repeat (Cpb) @(negedge clk);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rxd = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wea_cnt = 0;
    done_cyc = -1;
    last_wea_cyc = -1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wea"}, 64'(wea), 64'd0);
    check({tag, "_addra"}, 64'(addra), 64'd0);
    check({tag, "_dina"}, 64'(dina), 64'd0);
    check({tag, "_count"}, 64'(instr_count), 64'd0);
    check({tag, "_done"}, 64'(load_done), 64'd0);
    check({tag, "_ferr"}, 64'(frame_err), 64'd0);
  endtask

  initial begin
    // 1: header plus two words
    do_reset();
    check_zero("reset");
    exp_q.push_back({8'd0, 56'h07060504030201});
    exp_q.push_back({8'd1, 56'h0E0D0C0B0A0908});
    send_byte(8'h02, 1'b1, 4);
    check("t1_count_after_hdr", 64'(instr_count), 64'd2);
    for (int i = 1; i <= 14; i++) send_byte(8'(i), 1'b1, 4);
    repeat (20) @(negedge clk);
    check("t1_wea_cnt", 64'(wea_cnt), 64'd2);
    check("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t1_count", 64'(instr_count), 64'd2);
    check("t1_done", 64'(load_done), 64'd1);
    check("t1_done_timing", 64'(done_cyc), 64'(last_wea_cyc + 1));
    check("t1_ferr", 64'(frame_err), 64'd0);

    // 2: zero-length program
    do_reset();
    send_byte(8'h00, 1'b1, 4);
    check("t2_done_after_hdr", 64'(load_done), 64'd1);
    check("t2_count", 64'(instr_count), 64'd0);
    send_byte(8'h55, 1'b1, 20);
    check("t2_wea_cnt", 64'(wea_cnt), 64'd0);
    check("t2_done", 64'(load_done), 64'd1);
    check("t2_count_after_data", 64'(instr_count), 64'd0);

    // 3: framing error discards a byte without advancing
    do_reset();
    exp_q.push_back({8'd0, 56'hA6A5A4A3A2A1A0});
    send_byte(8'h01, 1'b1, 4);
    send_byte(8'h11, 1'b0, 8);
    check("t3_ferr", 64'(frame_err), 64'd1);
    check("t3_no_wea_yet", 64'(wea_cnt), 64'd0);
    for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i), 1'b1, 4);
    repeat (20) @(negedge clk);
    check("t3_wea_cnt", 64'(wea_cnt), 64'd1);
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t3_done", 64'(load_done), 64'd1);
    check("t3_ferr_sticky", 64'(frame_err), 64'd1);

    // 4: short low glitch while idle
    do_reset();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("t4_glitch_count", 64'(instr_count), 64'd0);
    check("t4_glitch_ferr", 64'(frame_err), 64'd0);
    exp_q.push_back({8'd0, 56'h16151413121110});
    send_byte(8'h01, 1'b1, 4);
    for (int i = 0; i < 7; i++) send_byte(8'h10 + 8'(i), 1'b1, 4);
    repeat (20) @(negedge clk);
    check("t4_count", 64'(instr_count), 64'd1);
    check("t4_wea_cnt", 64'(wea_cnt), 64'd1);
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // 5: reset in the middle of a word
    do_reset();
    send_byte(8'h03, 1'b1, 4);
    check("t5_count_before_rst", 64'(instr_count), 64'd3);
    for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 1'b1, 4);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_zero("t5_during_rst");
    rst = 1'b0;
    @(negedge clk);
    check_zero("t5_after_rst");
    wea_cnt = 0;
    exp_q.push_back({8'd0, 56'hFFFFFFFFFFFFFF});
    send_byte(8'h01, 1'b1, 4);
    for (int i = 0; i < 7; i++) send_byte(8'hFF, 1'b1, 4);
    repeat (20) @(negedge clk);
    check("t5_wea_cnt", 64'(wea_cnt), 64'd1);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t5_count", 64'(instr_count), 64'd1);
    check("t5_done", 64'(load_done), 64'd1);

    // 6: back-to-back frames followed by trailing bytes
    do_reset();
    exp_q.push_back({8'd0, 56'h36353433323130});
    send_byte(8'h01, 1'b1, 0);
    for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i), 1'b1, 0);
    send_byte(8'h77, 1'b1, 0);
    send_byte(8'h88, 1'b1, 0);
    send_byte(8'h99, 1'b1, 20);
    check("t6_wea_cnt", 64'(wea_cnt), 64'd1);
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t6_addra", 64'(addra), 64'd0);
    check("t6_dina", 64'(dina), 64'h36353433323130);
    check("t6_count", 64'(instr_count), 64'd1);
    check("t6_done", 64'(load_done), 64'd1);
    check("t6_ferr", 64'(frame_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
